// File: rtl/ltl_report_arbiter_pkg.sv
// Shared defaults and FSM encoding for the LTL monitor report arbiter.
package ltl_monitor_pkg;

    localparam int NUM_PROPS_DEF = 9;
    localparam int ID_W_DEF      = 4;
    localparam int CNT_W_DEF     = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

endpackage

// File: rtl/ltl_report_arbiter_if.sv
// Report channel between the arbiter (master) and its consumer (slave).
// Handshake: a report transfers on a rising edge where rpt_valid_o && rpt_ready_i;
// while rpt_valid_o && !rpt_ready_i, rpt_id_o/rpt_count_o hold stable and valid stays high.
interface ltl_report_arbiter_if #(
    parameter int ID_W  = 4,
    parameter int CNT_W = 8
);
    logic             rpt_valid_o;
    logic             rpt_ready_i;
    logic [ID_W-1:0]  rpt_id_o;
    logic [CNT_W-1:0] rpt_count_o;

    modport master (
        output rpt_valid_o,
        output rpt_id_o,
        output rpt_count_o,
        input  rpt_ready_i
    );

    modport slave (
        input  rpt_valid_o,
        input  rpt_id_o,
        input  rpt_count_o,
        output rpt_ready_i
    );
endinterface

// File: rtl/ltl_report_arbiter_rr_pick.sv
// Combinational round-robin first-one search over req_i, starting at start_i and wrapping.
module ltl_rr_pick #(
    parameter int N  = 9,
    parameter int IW = 4
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] start_i,
    output logic [IW-1:0] idx_o,
    output logic          found_o
);

    always_comb begin
        int j;
        idx_o   = '0;
        found_o = 1'b0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(start_i) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!found_o && req_i[j]) begin
                found_o = 1'b1;
                idx_o   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/ltl_report_arbiter.sv
// Collects per-property LTL hits into saturating counters and reports them one at a time,
// round-robin, over a valid/ready channel.
module ltl_report_arbiter
    import ltl_monitor_pkg::*;
#(
    parameter int NUM_PROPS = NUM_PROPS_DEF,
    parameter int ID_W      = ID_W_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 run_i,
    input  logic [NUM_PROPS-1:0] hit_i,
    input  logic                 clear_i,
    ltl_report_arbiter_if.master rpt,
    output logic [NUM_PROPS-1:0] pending_o,
    output logic                 overflow_o,
    output state_t               state_o
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_valid;
    logic [ID_W-1:0]      r_id;
    logic [CNT_W-1:0]     r_count;
    logic [NUM_PROPS-1:0] r_pending;
    logic [CNT_W-1:0]     r_cnt [NUM_PROPS];
    logic                 r_overflow;
    logic [ID_W-1:0]      r_ptr;

    logic [NUM_PROPS-1:0] w_hit;
    logic [NUM_PROPS-1:0] w_pend_upd;
    logic [NUM_PROPS-1:0] w_pick_req;
    logic [ID_W-1:0]      w_pick_idx;
    logic                 w_found;
    logic                 w_capture;

    assign w_hit      = run_i ? hit_i : '0;
    assign w_pend_upd = r_pending | w_hit;
    // From IDLE only already-registered pending bits win (one-cycle latency);
    // on a handshake, hits landing on that edge are eligible too.
    assign w_pick_req = (r_state == IDLE) ? r_pending : w_pend_upd;

    ltl_rr_pick #(
        .N  (NUM_PROPS),
        .IW (ID_W)
    ) u_pick (
        .req_i   (w_pick_req),
        .start_i (r_ptr),
        .idx_o   (w_pick_idx),
        .found_o (w_found)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        if (clear_i) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        w_state_nxt = OFFER;
                        w_capture   = 1'b1;
                    end
                end
                OFFER: begin
                    if (rpt.rpt_ready_i) begin
                        if (w_found) begin
                            w_capture = 1'b1;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= (w_state_nxt == OFFER);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pending  <= '0;
            r_overflow <= 1'b0;
            r_ptr      <= '0;
            r_id       <= '0;
            r_count    <= '0;
            for (int i = 0; i < NUM_PROPS; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (clear_i) begin
            r_pending  <= '0;
            r_overflow <= 1'b0;
            r_ptr      <= '0;
            for (int i = 0; i < NUM_PROPS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PROPS; i++) begin
                if (w_capture && (int'(w_pick_idx) == i)) begin
                    // A fresh hit on an already-pending winner starts the next batch;
                    // a winner pending only through this edge's hit is reported as that hit.
                    if (r_pending[i] && w_hit[i]) begin
                        r_pending[i] <= 1'b1;
                        r_cnt[i]     <= CNT_W'(1);
                    end else begin
                        r_pending[i] <= 1'b0;
                        r_cnt[i]     <= '0;
                    end
                end else if (w_hit[i]) begin
                    r_pending[i] <= 1'b1;
                    if (r_cnt[i] == {CNT_W{1'b1}}) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                    end
                end
            end
            if (w_capture) begin
                r_id    <= w_pick_idx;
                r_count <= r_pending[w_pick_idx] ? r_cnt[w_pick_idx] : CNT_W'(1);
                r_ptr   <= (w_pick_idx == ID_W'(NUM_PROPS - 1)) ? '0 : w_pick_idx + ID_W'(1);
            end
        end
    end

    assign rpt.rpt_valid_o = r_valid;
    assign rpt.rpt_id_o    = r_id;
    assign rpt.rpt_count_o = r_count;
    assign pending_o       = r_pending;
    assign overflow_o      = r_overflow;
    assign state_o         = r_state;

endmodule

// File: tb/tb_ltl_report_arbiter.sv
// Directed bench for ltl_report_arbiter: one task per scenario, inline checks, summary line.
module tb_ltl_report_arbiter;
    import ltl_monitor_pkg::*;

    logic       clk_i;
    logic       rst_ni;
    logic       run_i;
    logic [8:0] hit_i;
    logic       clear_i;
    logic [8:0] pending_o;
    logic       overflow_o;
    state_t     state_o;

    int n_vec = 0;
    int n_err = 0;

    ltl_report_arbiter_if #(.ID_W(4), .CNT_W(8)) rpt_if ();

    ltl_report_arbiter #(
        .NUM_PROPS (9),
        .ID_W      (4),
        .CNT_W     (8)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .run_i      (run_i),
        .hit_i      (hit_i),
        .clear_i    (clear_i),
        .rpt        (rpt_if),
        .pending_o  (pending_o),
        .overflow_o (overflow_o),
        .state_o    (state_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Advance one rising edge; inputs are driven and outputs sampled 1ns after it.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        run_i  = 1'b1;
        hit_i  = '0;
        clear_i = 1'b0;
        rpt_if.rpt_ready_i = 1'b0;
        step();
        step();
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        run_i  = 1'b0;
        hit_i  = '0;
        clear_i = 1'b0;
        rpt_if.rpt_ready_i = 1'b0;
        #3;
        n_vec++; if (rpt_if.rpt_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", rpt_if.rpt_valid_o); end
        n_vec++; if (rpt_if.rpt_id_o !== 4'd0) begin n_err++; $display("FAIL reset_id: got %0d want 0", rpt_if.rpt_id_o); end
        n_vec++; if (rpt_if.rpt_count_o !== 8'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", rpt_if.rpt_count_o); end
        n_vec++; if (pending_o !== 9'h000) begin n_err++; $display("FAIL reset_pending: got %h want 000", pending_o); end
        n_vec++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", overflow_o); end
        n_vec++; if (state_o !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d want IDLE", state_o); end
        step();
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_run_gate();
        do_reset();
        run_i = 1'b0;
        hit_i = 9'h1FF;
        step();
        hit_i = '0;
        step();
        n_vec++; if (pending_o !== 9'h000) begin n_err++; $display("FAIL run_gate_pending: got %h want 000", pending_o); end
        n_vec++; if (rpt_if.rpt_valid_o !== 1'b0) begin n_err++; $display("FAIL run_gate_valid: got %b want 0", rpt_if.rpt_valid_o); end
        run_i = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        rpt_if.rpt_ready_i = 1'b1;
        hit_i = 9'h004;
        step();
        hit_i = '0;
        n_vec++; if (pending_o !== 9'h004) begin n_err++; $display("FAIL single_pend_e0: got %h want 004", pending_o); end
        n_vec++; if (rpt_if.rpt_valid_o !== 1'b0) begin n_err++; $display("FAIL single_valid_e0: got %b want 0", rpt_if.rpt_valid_o); end
        step();
        n_vec++; if (rpt_if.rpt_valid_o !== 1'b1) begin n_err++; $display("FAIL single_valid_e1: got %b want 1", rpt_if.rpt_valid_o); end
        n_vec++; if (rpt_if.rpt_id_o !== 4'd2) begin n_err++; $display("FAIL single_id: got %0d want 2", rpt_if.rpt_id_o); end
        n_vec++; if (rpt_if.rpt_count_o !== 8'd1) begin n_err++; $display("FAIL single_count: got %0d want 1", rpt_if.rpt_count_o); end
        n_vec++; if (pending_o !== 9'h000) begin n_err++; $display("FAIL single_pend_e1: got %h want 000", pending_o); end
        step();
        n_vec++; if (rpt_if.rpt_valid_o !== 1'b0) begin n_err++; $display("FAIL single_valid_e2: got %b want 0", rpt_if.rpt_valid_o); end
        n_vec++; if (state_o !== IDLE) begin n_err++; $display("FAIL single_state_e2: got %0d want IDLE", state_o); end
        n_vec++; if (rpt_if.rpt_id_o !== 4'd2) begin n_err++; $display("FAIL single_id_hold: got %0d want 2", rpt_if.rpt_id_o); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_q[$];
        logic [3:0] exp_id;
        do_reset();
        for (int i = 0; i < 9; i++) exp_q.push_back(4'(i));
        rpt_if.rpt_ready_i = 1'b1;
        hit_i = 9'h1FF;
        step();
        hit_i = '0;
        n_vec++; if (pending_o !== 9'h1FF) begin n_err++; $display("FAIL b2b_pend: got %h want 1ff", pending_o); end
        for (int i = 0; i < 9; i++) begin
            step();
            exp_id = exp_q.pop_front();
            n_vec++; if (rpt_if.rpt_valid_o !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, rpt_if.rpt_valid_o); end
            n_vec++; if (rpt_if.rpt_id_o !== exp_id) begin n_err++; $display("FAIL b2b_id[%0d]: got %0d want %0d", i, rpt_if.rpt_id_o, exp_id); end
            n_vec++; if (rpt_if.rpt_count_o !== 8'd1) begin n_err++; $display("FAIL b2b_count[%0d]: got %0d want 1", i, rpt_if.rpt_count_o); end
        end
        step();
        n_vec++; if (rpt_if.rpt_valid_o !== 1'b0) begin n_err++; $display("FAIL b2b_end_valid: got %b want 0", rpt_if.rpt_valid_o); end
    endtask

    task automatic test_saturation();
        do_reset();
        rpt_if.rpt_ready_i = 1'b0;
        hit_i = 9'h008;
        for (int i = 0; i < 300; i++) begin
            step();
            if (i == 255) begin
                n_vec++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL sat_ovf_early: got %b want 0", overflow_o); end
            end
            if (i == 256) begin
                n_vec++; if (overflow_o !== 1'b1) begin n_err++; $display("FAIL sat_ovf_set: got %b want 1", overflow_o); end
            end
        end
        hit_i = '0;
        n_vec++; if (rpt_if.rpt_id_o !== 4'd3) begin n_err++; $display("FAIL sat_first_id: got %0d want 3", rpt_if.rpt_id_o); end
        n_vec++; if (rpt_if.rpt_count_o !== 8'd1) begin n_err++; $display("FAIL sat_first_count: got %0d want 1", rpt_if.rpt_count_o); end
        rpt_if.rpt_ready_i = 1'b1;
        step();
        n_vec++; if (rpt_if.rpt_valid_o !== 1'b1) begin n_err++; $display("FAIL sat_second_valid: got %b want 1", rpt_if.rpt_valid_o); end
        n_vec++; if (rpt_if.rpt_id_o !== 4'd3) begin n_err++; $display("FAIL sat_second_id: got %0d want 3", rpt_if.rpt_id_o); end
        n_vec++; if (rpt_if.rpt_count_o !== 8'd255) begin n_err++; $display("FAIL sat_second_count: got %0d want 255", rpt_if.rpt_count_o); end
        step();
        n_vec++; if (rpt_if.rpt_valid_o !== 1'b0) begin n_err++; $display("FAIL sat_end_valid: got %b want 0", rpt_if.rpt_valid_o); end
        n_vec++; if (overflow_o !== 1'b1) begin n_err++; $display("FAIL sat_ovf_sticky: got %b want 1", overflow_o); end
    endtask

    task automatic test_hold();
        do_reset();
        rpt_if.rpt_ready_i = 1'b0;
        hit_i = 9'h020;
        step();
        hit_i = '0;
        step();
        for (int i = 0; i < 4; i++) begin
            hit_i = (i % 2 == 0) ? 9'h020 : 9'h000;
            step();
            n_vec++; if (rpt_if.rpt_valid_o !== 1'b1 || rpt_if.rpt_id_o !== 4'd5 || rpt_if.rpt_count_o !== 8'd1) begin
                n_err++; $display("FAIL hold_stable[%0d]: got v=%b id=%0d cnt=%0d want v=1 id=5 cnt=1", i, rpt_if.rpt_valid_o, rpt_if.rpt_id_o, rpt_if.rpt_count_o);
            end
        end
        hit_i = '0;
        rpt_if.rpt_ready_i = 1'b1;
        step();
        n_vec++; if (rpt_if.rpt_id_o !== 4'd5) begin n_err++; $display("FAIL hold_next_id: got %0d want 5", rpt_if.rpt_id_o); end
        n_vec++; if (rpt_if.rpt_count_o !== 8'd2) begin n_err++; $display("FAIL hold_next_count: got %0d want 2", rpt_if.rpt_count_o); end
        step();
        n_vec++; if (rpt_if.rpt_valid_o !== 1'b0) begin n_err++; $display("FAIL hold_end_valid: got %b want 0", rpt_if.rpt_valid_o); end
    endtask

    task automatic test_clear();
        do_reset();
        rpt_if.rpt_ready_i = 1'b0;
        hit_i = 9'h082;
        step();
        hit_i = '0;
        step();
        n_vec++; if (rpt_if.rpt_id_o !== 4'd1 || pending_o !== 9'h080) begin
            n_err++; $display("FAIL clear_pre: got id=%0d pend=%h want id=1 pend=080", rpt_if.rpt_id_o, pending_o);
        end
        clear_i = 1'b1;
        hit_i = 9'h010;
        step();
        clear_i = 1'b0;
        hit_i = '0;
        n_vec++; if (rpt_if.rpt_valid_o !== 1'b0) begin n_err++; $display("FAIL clear_valid: got %b want 0", rpt_if.rpt_valid_o); end
        n_vec++; if (pending_o !== 9'h000) begin n_err++; $display("FAIL clear_pending: got %h want 000", pending_o); end
        rpt_if.rpt_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_vec++; if (rpt_if.rpt_valid_o !== 1'b0) begin n_err++; $display("FAIL clear_quiet[%0d]: got %b want 0", i, rpt_if.rpt_valid_o); end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        rpt_if.rpt_ready_i = 1'b0;
        hit_i = 9'h041;
        step();
        hit_i = '0;
        step();
        n_vec++; if (rpt_if.rpt_valid_o !== 1'b1) begin n_err++; $display("FAIL arst_pre_valid: got %b want 1", rpt_if.rpt_valid_o); end
        #2;
        rst_ni = 1'b0;
        #1;
        n_vec++; if (rpt_if.rpt_valid_o !== 1'b0) begin n_err++; $display("FAIL arst_valid: got %b want 0", rpt_if.rpt_valid_o); end
        n_vec++; if (rpt_if.rpt_id_o !== 4'd0 || rpt_if.rpt_count_o !== 8'd0) begin
            n_err++; $display("FAIL arst_id_count: got id=%0d cnt=%0d want 0 0", rpt_if.rpt_id_o, rpt_if.rpt_count_o);
        end
        n_vec++; if (pending_o !== 9'h000 || overflow_o !== 1'b0) begin
            n_err++; $display("FAIL arst_pend_ovf: got pend=%h ovf=%b want 000 0", pending_o, overflow_o);
        end
        step();
        rst_ni = 1'b1;
        step();
        n_vec++; if (rpt_if.rpt_valid_o !== 1'b0) begin n_err++; $display("FAIL arst_after_valid: got %b want 0", rpt_if.rpt_valid_o); end
    endtask

    initial begin
        test_reset();
        test_run_gate();
        test_single();
        test_back_to_back();
        test_saturation();
        test_hold();
        test_clear();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ltl_report_arbiter.md
LTL_REPORT_ARBITER -- requirements
Module: ltl_report_arbiter

Interface
REQ-001 Parameter NUM_PROPS, default 9: number of LTL property hit lines arbitrated (ltl0..ltl8 of one cluster).
REQ-002 Parameter ID_W, default 4: width of the reported property index.
REQ-003 Parameter CNT_W, default 8: width of per-property hit counters.
REQ-004 clk_i  input  1  single clock; all state changes on the rising edge.
REQ-005 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-006 run_i  input  1  monitor enable; hits are sampled only while high.
REQ-007 hit_i  input  NUM_PROPS  per-property violation flags from the cluster top, bit i = ltl<i>.
REQ-008 clear_i  input  1  synchronous flush of all pending state.
REQ-009 rpt_valid_o  output  1  report offered.
REQ-010 rpt_ready_i  input  1  report consumer ready.
REQ-011 rpt_id_o  output  ID_W  property index of offered report.
REQ-012 rpt_count_o  output  CNT_W  hits accumulated for rpt_id_o since its previous capture.
REQ-013 pending_o  output  NUM_PROPS  per-property pending flags, registered.
REQ-014 overflow_o  output  1  sticky: some counter hit saturation.

Function
REQ-015 Per property i: on an edge with run_i=1 and hit_i[i]=1, pending[i] is set and cnt[i] increments, saturating at 2^CNT_W-1.
REQ-016 An increment attempted on a saturated counter sets overflow_o; overflow_o clears only via clear_i or reset.
REQ-017 With run_i=0, hit_i is ignored; an in-flight offer and existing pending state are unaffected.
REQ-018 FSM states IDLE and OFFER; rpt_valid_o=1 exactly in OFFER.
REQ-019 IDLE->OFFER on the edge where any pending bit is 1: the winner is captured into rpt_id_o/rpt_count_o.
REQ-020 Capture also clears that winner's pending bit and cnt on the same edge. A same-edge hit for the winner instead leaves pending=1, cnt=1.
REQ-021 Winner selection is round-robin: search starts at index (last granted + 1) mod NUM_PROPS; after reset/clear the search starts at index 0.
REQ-022 In OFFER with rpt_ready_i=0: rpt_id_o and rpt_count_o hold stable, and rpt_valid_o stays 1.
REQ-023 In OFFER with rpt_ready_i=1 (handshake): if any pending bit remains after this edge's update, stay in OFFER and capture the next winner on the same edge (one report per cycle sustained). Otherwise go to IDLE.
REQ-024 Pending bits considered for recapture on a handshake edge include hits sampled on that same edge.
REQ-025 Latency: hit sampled at edge E0 with FSM idle and no other pending -> rpt_valid_o=1 after edge E1.
REQ-026 clear_i=1 (priority over hits and handshake): pending, all cnt and overflow_o cleared; round-robin pointer reset; FSM->IDLE; an unaccepted offer is withdrawn.
REQ-027 A hit on the same edge as clear_i is discarded.
REQ-028 rpt_id_o and rpt_count_o hold their last captured value in IDLE.

Reset
REQ-029 While rst_ni=0: FSM=IDLE, rpt_valid_o=0, rpt_id_o=0, rpt_count_o=0, pending_o=0, all cnt=0, overflow_o=0, round-robin pointer=0. All registers reset asynchronously.
REQ-030 Reset asserted mid-offer drops rpt_valid_o immediately (asynchronously) and loses all pending reports.

Structure
REQ-031 A shared package ltl_monitor_pkg holds NUM_PROPS, ID_W, CNT_W defaults and the FSM state enum (IDLE, OFFER).
REQ-032 One sub-module, ltl_rr_pick (combinational round-robin first-one search from a start index, returning index and found flag), is instantiated once.
REQ-033 All outputs are driven directly from registers.

Verification
REQ-034 Scenario: reset, run_i=1, hit_i=9'h004 for one cycle, rpt_ready_i=1 -> one report id=2 count=1, valid high for exactly one cycle after E1, then IDLE.
REQ-035 Scenario: hit_i=9'h1FF one cycle, ready=1 -> nine back-to-back reports, ids 0..8 in order, each count=1, no gaps.
REQ-036 Scenario: ready=0, hit_i[3]=1 for 300 cycles, then ready=1 -> first report id=3 count=1; second report id=3 count=255; overflow_o=1.
REQ-037 Scenario: offer for id=5 held with ready=0 while hit_i[5] pulses twice -> rpt_id_o/rpt_count_o stable during the hold; the next report is id=5 count=2.
REQ-038 Scenario: pending ids 1 and 7, clear_i asserted while offering id=1 together with hit_i[4] -> valid drops next cycle, pending_o=0, no further reports.
REQ-039 Scenario: rst_ni pulsed low mid-offer -> rpt_valid_o=0 before the next clock edge, all outputs at reset values.
